// File: rtl/apb4_csr_bridge.sv
// APB4 completer issuing one CSR bus request per transfer, never pipelined.
// Optional WAIT-state timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb4_csr_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    bus_req,
  output logic                    bus_req_is_wr,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wr_data,
  output logic [DATA_WIDTH-1:0]   bus_wr_biten,
  output logic                    bus_req_stall_wr,
  output logic                    bus_req_stall_rd,
  input  logic                    bus_ready,
  input  logic                    bus_err,
  input  logic [DATA_WIDTH-1:0]   bus_rd_data
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy;
  logic                  expired;
  logic                  unused_pprot;

  assign unused_pprot = ^pprot;
  assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Held at zero in IDLE so it is clear on REQ entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign expired = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES[0];
`endif

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (psel && penable) begin
          wr_d    = pwrite;
          addr_d  = paddr;
          wdata_d = pwdata;
          strb_d  = pstrb;
          if (paddr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        // A completion in the expiry cycle beats the timeout.
        if (bus_ready) begin
          rdata_d = bus_rd_data;
          err_d   = bus_err;
          state_d = S_RESP;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus_wr_biten = '0;
    for (int i = 0; i < SW; i++) begin
      bus_wr_biten[8*i +: 8] = {8{strb_q[i] & wr_q}};
    end
  end

  assign pready           = (state_q == S_RESP);
  assign prdata           = (pready && !wr_q) ? rdata_q : '0;
  assign pslverr          = pready && err_q;
  assign bus_req          = (state_q == S_REQ);
  assign bus_req_is_wr    = wr_q;
  assign bus_addr         = addr_q;
  assign bus_wr_data      = wdata_q;
  assign bus_req_stall_wr = busy && wr_q;
  assign bus_req_stall_rd = busy && !wr_q;

endmodule
